ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_ctrl.sv | 101 ++++++++++
 tb/tb_ifetch_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads a combinational imem,
// and buffers {pc, instr, fault} entries in a small FIFO handed to decode.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter int          ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [1:0]  if_fault
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD   = CW'(QDEPTH);
  localparam logic [PW-1:0] PMAX = PW'(QDEPTH - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } fq_entry_t;

  typedef enum logic {RUN, HALT} state_t;

  fq_entry_t     q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  state_t        state, state_d;
  logic [1:0]    fault;
  logic          pop, push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PMAX) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign if_pc     = q[head].pc;
  assign if_instr  = q[head].instr;
  assign if_fault  = q[head].fault;

  // Misalignment takes precedence over range.
  always_comb begin
    fault = 2'b00;
    if (fetch_pc[1:0] != 2'b00)                 fault = 2'b01;
    else if ((fetch_pc >> ADDR_BITS) != 32'd0)  fault = 2'b10;
  end

  always_comb begin
    state_d = state;
    pop     = if_valid && if_ready;
    push    = 1'b0;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (state == RUN) begin
      push = (count < QD) || pop;
      if (push && (fault != 2'b00)) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      state    <= RUN;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      // Flush; a same-cycle pop is already consumed by decode.
      fetch_pc <= redirect_pc;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      state    <= state_d;
    end else begin
      state <= state_d;
      if (push) begin
        q[tail] <= '{pc: fetch_pc,
                     instr: (fault != 2'b00) ? 32'd0 : imem_data,
                     fault: fault};
        tail    <= nxt(tail);
        if (fault == 2'b00) fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) head <= nxt(head);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios then random traffic, checked
// against a queue-based reference model of the fetch stream.
module tb_ifetch_ctrl;
  localparam int          QDEPTH    = 2;
  localparam int          ADDR_BITS = 12;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk, rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [1:0]  if_fault;

  ifetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_data = 32'h1000_0000 + imem_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          nvec, errs;

  function automatic logic [1:0] mfault(input logic [31:0] pc);
    if (pc % 4 != 0)                    return 2'b01;
    if (64'(pc) >= (64'd1 << ADDR_BITS)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit red, input logic [31:0] rpc, input bit rdy);
    bit         popd, can;
    logic [1:0] f;
    rst_n = !rst; redirect_valid = red; redirect_pc = rpc; if_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_pc = RESET_PC; m_halt = 0;
    end else if (red) begin
      mq.delete(); m_pc = rpc; m_halt = 0;
    end else begin
      popd = rdy && (mq.size() > 0);
      can  = !m_halt && ((mq.size() < QDEPTH) || popd);
      if (popd) void'(mq.pop_front());
      if (can) begin
        f = mfault(m_pc);
        mq.push_back('{pc: m_pc, instr: (f != 2'b00) ? 32'd0 : 32'h1000_0000 + m_pc, fault: f});
        if (f != 2'b00) m_halt = 1;
        else            m_pc = m_pc + 32'd4;
      end
    end
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_instr", if_instr, mq[0].instr);
      chk("if_fault", 32'(if_fault), 32'(mq[0].fault));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_fault", 32'(if_fault), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    logic [31:0] rpc;
    int          r, sel;
    bit          rst, red, rdy;
    nvec = 0; errs = 0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    m_pc = RESET_PC; m_halt = 0;

    // Reset, then free-running fetch.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_reset_outputs();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Backpressure after reset: queue saturates, fetch PC holds at 0x8.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall_imem_addr", imem_addr, 32'h8);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Full queue plus redirect with a same-cycle pop.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 1);
    chk("redir_flush_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Misaligned target yields one fault entry then halts; realigned resumes.
    step(0, 1, 32'h42, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("halt_valid", 32'(if_valid), 32'd0);
    step(0, 1, 32'h10, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Back-to-back redirects: last wins.
    step(0, 1, 32'h80, 1);
    step(0, 1, 32'h100, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Walk off the end of instruction memory.
    step(0, 1, 32'hFF8, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);

    // Reset with full queue and a pending redirect.
    step(0, 1, 32'h20, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 32'h200, 1);
    chk_reset_outputs();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      red = (r >= 2) && (r < 12);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       rpc = 32'hFF0;
        1:       rpc = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        2:       rpc = 32'h2000_0000 + 32'($urandom_range(0, 15)) * 4;
        default: rpc = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      step(rst, red, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
